marie_control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
- Sits directly upstream of the datapath registers (PC, MAR, MBR, IR, AC), the ALU and main memory, and drives their load/enable/select strobes.
- Consumes the IR output and AC value; implements Load, Store, Add, Subt, Halt, Skipcond, Jump, Clear.

---
 rtl/marie_control_unit.sv | 167 ++++++++++++++++
 tb/tb_marie_control_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/marie_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the MARIE accumulator CPU.
// Strobes are decoded from the state register plus ir_in/ac_in.
module marie_control_unit #(
    parameter int DATA_W = 16,
    parameter int OPND_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] ir_in,
    input  logic [DATA_W-1:0] ac_in,
    output logic              mar_load,
    output logic              mar_src,
    output logic              mem_we,
    output logic              mbr_load,
    output logic              mbr_src,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_load_addr,
    output logic [3:0]        alu_op,
    output logic              ac_load,
    output logic [1:0]        ac_src,
    output logic              halted,
    output logic              illegal,
    output logic [3:0]        state_out,
    output logic [DATA_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH_MAR = 4'd1,
        FETCH_MEM = 4'd2,
        FETCH_IR  = 4'd3,
        DECODE    = 4'd4,
        EXEC_MEM  = 4'd5,
        EXEC_MBR  = 4'd6,
        EXEC_AC   = 4'd7,
        STORE_MBR = 4'd8,
        STORE_WR  = 4'd9,
        HALT      = 4'd10
    } state_t;

    state_t      state;
    logic [3:0]  opcode;
    logic [1:0]  skip_cond;
    logic        ac_neg;
    logic        ac_zero;
    logic        skip;
    logic        instr_done;

    assign opcode       = ir_in[DATA_W-1 -: 4];
    assign skip_cond    = ir_in[OPND_W-1 -: 2];
    assign ac_neg       = ac_in[DATA_W-1];
    assign ac_zero      = (ac_in == '0);
    assign pc_load_addr = {{(DATA_W-OPND_W){1'b0}}, ir_in[OPND_W-1:0]};
    assign state_out    = state;

    always_comb begin
        skip = 1'b0;
        case (skip_cond)
            2'b00:   skip = ac_neg;
            2'b01:   skip = ac_zero;
            2'b10:   skip = !ac_neg && !ac_zero;
            default: skip = 1'b0;
        endcase
    end

    // The "END" pseudo-state: last cycle of any counted instruction.
    always_comb begin
        instr_done = 1'b0;
        case (state)
            DECODE:   instr_done = (opcode == 4'h8) || (opcode == 4'h9) || (opcode == 4'hA);
            EXEC_AC:  instr_done = 1'b1;
            STORE_WR: instr_done = 1'b1;
            default:  instr_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instr_count <= '0;
            illegal     <= 1'b0;
            halted      <= 1'b0;
        end else if (instr_done) begin
            instr_count <= instr_count + 1'b1;
            state       <= run ? FETCH_MAR : IDLE;
        end else begin
            case (state)
                IDLE:      if (run) state <= FETCH_MAR;
                FETCH_MAR: state <= FETCH_MEM;
                FETCH_MEM: state <= FETCH_IR;
                FETCH_IR:  state <= DECODE;
                DECODE: begin
                    case (opcode)
                        4'h1, 4'h3, 4'h4: state <= EXEC_MEM;
                        4'h2:             state <= STORE_MBR;
                        4'h7: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        default: begin
                            illegal <= 1'b1;
                            halted  <= 1'b1;
                            state   <= HALT;
                        end
                    endcase
                end
                EXEC_MEM:  state <= EXEC_MBR;
                EXEC_MBR:  state <= EXEC_AC;
                STORE_MBR: state <= STORE_WR;
                HALT:      state <= HALT;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mar_load = 1'b0;
        mar_src  = 1'b0;
        mem_we   = 1'b0;
        mbr_load = 1'b0;
        mbr_src  = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_op   = 4'b0000;
        ac_load  = 1'b0;
        ac_src   = 2'd0;
        case (state)
            FETCH_MAR: mar_load = 1'b1;
            FETCH_IR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            DECODE: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4: begin
                        mar_load = 1'b1;
                        mar_src  = 1'b1;
                    end
                    4'h8: pc_inc  = skip;
                    4'h9: pc_load = 1'b1;
                    4'hA: begin
                        ac_load = 1'b1;
                        ac_src  = 2'd2;
                    end
                    default: ;
                endcase
            end
            EXEC_MBR: mbr_load = 1'b1;
            EXEC_AC: begin
                ac_load = 1'b1;
                if (opcode == 4'h1) ac_src = 2'd1;
                if (opcode == 4'h4) alu_op = 4'b0001;
            end
            STORE_MBR: begin
                mbr_load = 1'b1;
                mbr_src  = 1'b1;
            end
            STORE_WR: mem_we = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_marie_control_unit.sv
// Directed self-checking bench for marie_control_unit; the bench plays the
// datapath by presenting ir_in/ac_in for each instruction.
module tb_marie_control_unit;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] ir_in;
    logic [15:0] ac_in;
    logic        mar_load, mar_src, mem_we, mbr_load, mbr_src, ir_load;
    logic        pc_inc, pc_load, ac_load, halted, illegal;
    logic [15:0] pc_load_addr, instr_count;
    logic [3:0]  alu_op, state_out;
    logic [1:0]  ac_src;
    logic [14:0] strobes;

    int checks = 0;
    int errors = 0;

    // Strobe vector bit layout: mar_load 14, mar_src 13, mem_we 12, mbr_load 11,
    // mbr_src 10, ir_load 9, pc_inc 8, pc_load 7, alu_op 6:3, ac_load 2, ac_src 1:0
    localparam logic [14:0] S_NONE  = 15'h0000;
    localparam logic [14:0] S_FMAR  = 15'h4000;
    localparam logic [14:0] S_FIR   = 15'h0300;
    localparam logic [14:0] S_DMAR  = 15'h6000;
    localparam logic [14:0] S_MBR   = 15'h0800;
    localparam logic [14:0] S_SMBR  = 15'h0C00;
    localparam logic [14:0] S_WE    = 15'h1000;
    localparam logic [14:0] S_PCINC = 15'h0100;
    localparam logic [14:0] S_PCLD  = 15'h0080;
    localparam logic [14:0] S_ACMBR = 15'h0005;
    localparam logic [14:0] S_ACADD = 15'h0004;
    localparam logic [14:0] S_ACSUB = 15'h000C;
    localparam logic [14:0] S_ACCLR = 15'h0006;

    marie_control_unit #(.DATA_W(16), .OPND_W(12)) dut (
        .clk(clk), .reset(reset), .run(run), .ir_in(ir_in), .ac_in(ac_in),
        .mar_load(mar_load), .mar_src(mar_src), .mem_we(mem_we),
        .mbr_load(mbr_load), .mbr_src(mbr_src), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .alu_op(alu_op), .ac_load(ac_load), .ac_src(ac_src),
        .halted(halted), .illegal(illegal), .state_out(state_out),
        .instr_count(instr_count)
    );

    assign strobes = {mar_load, mar_src, mem_we, mbr_load, mbr_src, ir_load,
                      pc_inc, pc_load, alu_op, ac_load, ac_src};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [14:0] sb);
        chk({tag, "_state"}, {28'd0, state_out}, {28'd0, st});
        chk({tag, "_strobes"}, {17'd0, strobes}, {17'd0, sb});
        cyc();
    endtask

    task automatic fetch(input string tag);
        step({tag, "_c1"}, 4'd1, S_FMAR);
        step({tag, "_c2"}, 4'd2, S_NONE);
        step({tag, "_c3"}, 4'd3, S_FIR);
    endtask

    task automatic mem_instr(input string tag, input logic [15:0] ir, input logic [14:0] ac_sb);
        ir_in = ir;
        fetch(tag);
        step({tag, "_c4"}, 4'd4, S_DMAR);
        step({tag, "_c5"}, 4'd5, S_NONE);
        step({tag, "_c6"}, 4'd6, S_MBR);
        step({tag, "_c7"}, 4'd7, ac_sb);
    endtask

    task automatic one_cycle_exec(input string tag, input logic [15:0] ir,
                                  input logic [15:0] ac, input logic [14:0] dec_sb);
        ir_in = ir;
        ac_in = ac;
        fetch(tag);
        step({tag, "_c4"}, 4'd4, dec_sb);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(mem_we && (mar_load || mbr_load || ir_load)) && !(pc_inc && pc_load)) else begin
                errors++;
                $error("FAIL excl observed=%b expected=no overlap", strobes);
            end
        end
    end

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        ir_in = 16'h0000;
        ac_in = 16'h0000;
        cyc();
        chk("rst_state", {28'd0, state_out}, 32'd0);
        chk("rst_strobes", {17'd0, strobes}, 32'd0);
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);

        // Load 0x100
        reset = 1'b0;
        run   = 1'b1;
        ir_in = 16'h1100;
        cyc();
        mem_instr("load", 16'h1100, S_ACMBR);
        chk("load_count", {16'd0, instr_count}, 32'd1);
        chk("load_next", {28'd0, state_out}, 32'd1);

        mem_instr("add", 16'h3101, S_ACADD);
        mem_instr("subt", 16'h4102, S_ACSUB);
        chk("prog_count", {16'd0, instr_count}, 32'd3);

        // Store 0x200
        ir_in = 16'h2200;
        ac_in = 16'h00AA;
        fetch("store");
        step("store_c4", 4'd4, S_DMAR);
        step("store_c5", 4'd8, S_SMBR);
        step("store_c6", 4'd9, S_WE);
        chk("store_count", {16'd0, instr_count}, 32'd4);
        chk("store_next", {28'd0, state_out}, 32'd1);

        one_cycle_exec("skz_t", 16'h8400, 16'h0000, S_PCINC);
        one_cycle_exec("skz_f", 16'h8400, 16'h0001, S_NONE);
        one_cycle_exec("skn_t", 16'h8000, 16'hFFFF, S_PCINC);
        one_cycle_exec("skn_f", 16'h8000, 16'h0000, S_NONE);
        one_cycle_exec("skp_t", 16'h8800, 16'h7FFF, S_PCINC);
        one_cycle_exec("skp_f", 16'h8800, 16'h8000, S_NONE);
        one_cycle_exec("skx", 16'h8C00, 16'hFFFF, S_NONE);
        chk("skip_count", {16'd0, instr_count}, 32'd11);

        ir_in = 16'h9123;
        fetch("jump");
        chk("jump_addr", {16'd0, pc_load_addr}, 32'h0123);
        step("jump_c4", 4'd4, S_PCLD);
        one_cycle_exec("clear", 16'hA000, 16'h1234, S_ACCLR);
        chk("jc_count", {16'd0, instr_count}, 32'd13);
        chk("jc_illegal", {31'd0, illegal}, 32'd0);

        one_cycle_exec("halt", 16'h7000, 16'h0000, S_NONE);
        for (int i = 0; i < 20; i++) begin
            chk("halt_state", {28'd0, state_out}, 32'd10);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_strobes", {17'd0, strobes}, 32'd0);
            chk("halt_count", {16'd0, instr_count}, 32'd13);
            cyc();
        end
        chk("halt_illegal", {31'd0, illegal}, 32'd0);

        // Fresh run with an illegal opcode
        reset = 1'b1;
        #1;
        chk("rst2_count", {16'd0, instr_count}, 32'd0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        one_cycle_exec("ill", 16'hF000, 16'h0000, S_NONE);
        chk("ill_state", {28'd0, state_out}, 32'd10);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_halted", {31'd0, halted}, 32'd1);
        chk("ill_count", {16'd0, instr_count}, 32'd0);

        // Reset during EXEC_MEM
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ir_in = 16'h2200;
        cyc();
        fetch("st2");
        step("st2_c4", 4'd4, S_DMAR);
        step("st2_c5", 4'd8, S_SMBR);
        step("st2_c6", 4'd9, S_WE);
        chk("st2_count", {16'd0, instr_count}, 32'd1);
        ir_in = 16'h1100;
        fetch("ld2");
        step("ld2_c4", 4'd4, S_DMAR);
        chk("mid_state", {28'd0, state_out}, 32'd5);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", {28'd0, state_out}, 32'd0);
        chk("mid_rst_strobes", {17'd0, strobes}, 32'd0);
        chk("mid_rst_count", {16'd0, instr_count}, 32'd0);
        chk("mid_rst_flags", {30'd0, halted, illegal}, 32'd0);
        cyc();

        // run dropped mid-Add: instruction completes, then IDLE
        reset = 1'b0;
        ir_in = 16'h3101;
        cyc();
        step("ra_c1", 4'd1, S_FMAR);
        step("ra_c2", 4'd2, S_NONE);
        run = 1'b0;
        step("ra_c3", 4'd3, S_FIR);
        step("ra_c4", 4'd4, S_DMAR);
        step("ra_c5", 4'd5, S_NONE);
        step("ra_c6", 4'd6, S_MBR);
        step("ra_c7", 4'd7, S_ACADD);
        chk("ra_idle", {28'd0, state_out}, 32'd0);
        chk("ra_count", {16'd0, instr_count}, 32'd1);
        cyc();
        cyc();
        step("ra_stay", 4'd0, S_NONE);
        run = 1'b1;
        cyc();
        chk("ra_resume", {28'd0, state_out}, 32'd1);
        chk("ra_resume_count", {16'd0, instr_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
